mips_alu: RTL and testbench

- Combinational 32-bit integer ALU for the EXE stage of the 5-stage MIPS pipeline.
- Computes the arithmetic, logic, shift, compare and multiply/divide result selected by a 6-bit control code.
- Produces next HI/LO values; the surrounding EXE stage stores them in its HI/LO registers each clock.
- The HI/LO registers live outside this block.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_divider.sv | 31 +++
 rtl/mips_alu.sv | 97 +++++++++
 tb/tb_mips_alu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the EXE-stage ALU: data width and 6-bit operation codes.
package alu_pkg;
   localparam int DATA_W = 32;

   localparam logic [5:0] ALU_ADD   = 6'd0;
   localparam logic [5:0] ALU_ADDU  = 6'd1;
   localparam logic [5:0] ALU_SUB   = 6'd2;
   localparam logic [5:0] ALU_SUBU  = 6'd3;
   localparam logic [5:0] ALU_AND   = 6'd4;
   localparam logic [5:0] ALU_OR    = 6'd5;
   localparam logic [5:0] ALU_XOR   = 6'd6;
   localparam logic [5:0] ALU_NOR   = 6'd7;
   localparam logic [5:0] ALU_SLT   = 6'd8;
   localparam logic [5:0] ALU_SLTU  = 6'd9;
   localparam logic [5:0] ALU_SLL   = 6'd10;
   localparam logic [5:0] ALU_SRL   = 6'd11;
   localparam logic [5:0] ALU_SRA   = 6'd12;
   localparam logic [5:0] ALU_SLLV  = 6'd13;
   localparam logic [5:0] ALU_SRLV  = 6'd14;
   localparam logic [5:0] ALU_SRAV  = 6'd15;
   localparam logic [5:0] ALU_LUI   = 6'd16;
   localparam logic [5:0] ALU_MULT  = 6'd17;
   localparam logic [5:0] ALU_MULTU = 6'd18;
   localparam logic [5:0] ALU_DIV   = 6'd19;
   localparam logic [5:0] ALU_DIVU  = 6'd20;
   localparam logic [5:0] ALU_MFHI  = 6'd21;
   localparam logic [5:0] ALU_MFLO  = 6'd22;
   localparam logic [5:0] ALU_MTHI  = 6'd23;
   localparam logic [5:0] ALU_MTLO  = 6'd24;
   localparam logic [5:0] ALU_PASSA = 6'd25;
   localparam logic [5:0] ALU_PASSB = 6'd26;
endpackage

// File: rtl/alu_divider.sv
// Combinational restoring array divider, unsigned 32/32 -> quotient, remainder.
// Zero latency; a zero divisor gives an all-ones quotient that the caller discards.
module alu_divider
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o
);

   always_comb begin
      logic [DATA_W-1:0] rem;
      logic [DATA_W:0]   trial;
      logic [DATA_W:0]   diff;
      rem        = '0;
      quotient_o = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         trial = {rem, dividend_i[i]};
         diff  = trial - {1'b0, divisor_i};
         if (!diff[DATA_W]) begin
            rem           = diff[DATA_W-1:0];
            quotient_o[i] = 1'b1;
         end else begin
            rem = trial[DATA_W-1:0];
         end
      end
      remainder_o = rem;
   end

endmodule

// File: rtl/mips_alu.sv
// EXE-stage 32-bit ALU producing the result and next HI/LO values.
// Purely combinational, zero latency; outputs forced to zero while RESET is low.
module mips_alu
   import alu_pkg::*;
(
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] HI_IN,
   input  logic [DATA_W-1:0] LO_IN,
   input  logic [DATA_W-1:0] OperandA_IN,
   input  logic [DATA_W-1:0] OperandB_IN,
   input  logic [5:0]        ALUControl_IN,
   input  logic [4:0]        ShiftAmount_IN,
   output logic [DATA_W-1:0] ALUResult_OUT,
   output logic [DATA_W-1:0] HI_OUT,
   output logic [DATA_W-1:0] LO_OUT
);

   logic              unused_clk;
   logic              div_signed, a_neg, b_neg, mul_signed;
   logic [DATA_W-1:0] div_a, div_b, div_q, div_r, sdiv_q, sdiv_r;
   logic [63:0]       mul_a, mul_b, product;
   logic [4:0]        var_sh;

   assign unused_clk = CLOCK;

   // Signed divide runs on magnitudes; signs are restored afterwards.
   assign div_signed = (ALUControl_IN == ALU_DIV);
   assign a_neg      = div_signed & OperandA_IN[DATA_W-1];
   assign b_neg      = div_signed & OperandB_IN[DATA_W-1];
   assign div_a      = a_neg ? -OperandA_IN : OperandA_IN;
   assign div_b      = b_neg ? -OperandB_IN : OperandB_IN;

   alu_divider u_div (
      .dividend_i  (div_a),
      .divisor_i   (div_b),
      .quotient_o  (div_q),
      .remainder_o (div_r)
   );

   assign sdiv_q = (a_neg ^ b_neg) ? -div_q : div_q;
   assign sdiv_r = a_neg ? -div_r : div_r;

   assign mul_signed = (ALUControl_IN == ALU_MULT);
   assign mul_a      = {{32{mul_signed & OperandA_IN[DATA_W-1]}}, OperandA_IN};
   assign mul_b      = {{32{mul_signed & OperandB_IN[DATA_W-1]}}, OperandB_IN};
   assign product    = mul_a * mul_b;
   assign var_sh     = OperandA_IN[4:0];

   always_comb begin
      ALUResult_OUT = '0;
      HI_OUT        = HI_IN;
      LO_OUT        = LO_IN;
      case (ALUControl_IN)
         ALU_ADD, ALU_ADDU: ALUResult_OUT = OperandA_IN + OperandB_IN;
         ALU_SUB, ALU_SUBU: ALUResult_OUT = OperandA_IN - OperandB_IN;
         ALU_AND:   ALUResult_OUT = OperandA_IN & OperandB_IN;
         ALU_OR:    ALUResult_OUT = OperandA_IN | OperandB_IN;
         ALU_XOR:   ALUResult_OUT = OperandA_IN ^ OperandB_IN;
         ALU_NOR:   ALUResult_OUT = ~(OperandA_IN | OperandB_IN);
         ALU_SLT:   ALUResult_OUT = {31'd0, $signed(OperandA_IN) < $signed(OperandB_IN)};
         ALU_SLTU:  ALUResult_OUT = {31'd0, OperandA_IN < OperandB_IN};
         ALU_SLL:   ALUResult_OUT = OperandB_IN << ShiftAmount_IN;
         ALU_SRL:   ALUResult_OUT = OperandB_IN >> ShiftAmount_IN;
         ALU_SRA:   ALUResult_OUT = $unsigned($signed(OperandB_IN) >>> ShiftAmount_IN);
         ALU_SLLV:  ALUResult_OUT = OperandB_IN << var_sh;
         ALU_SRLV:  ALUResult_OUT = OperandB_IN >> var_sh;
         ALU_SRAV:  ALUResult_OUT = $unsigned($signed(OperandB_IN) >>> var_sh);
         ALU_LUI:   ALUResult_OUT = {OperandB_IN[15:0], 16'h0000};
         ALU_MULT, ALU_MULTU: begin
            HI_OUT = product[63:32];
            LO_OUT = product[31:0];
         end
         ALU_DIV: if (OperandB_IN != '0) begin
            HI_OUT = sdiv_r;
            LO_OUT = sdiv_q;
         end
         ALU_DIVU: if (OperandB_IN != '0) begin
            HI_OUT = div_r;
            LO_OUT = div_q;
         end
         ALU_MFHI:  ALUResult_OUT = HI_IN;
         ALU_MFLO:  ALUResult_OUT = LO_IN;
         ALU_MTHI:  HI_OUT = OperandA_IN;
         ALU_MTLO:  LO_OUT = OperandA_IN;
         ALU_PASSA: ALUResult_OUT = OperandA_IN;
         ALU_PASSB: ALUResult_OUT = OperandB_IN;
         default:   ALUResult_OUT = '0;
      endcase
      if (!RESET) begin
         ALUResult_OUT = '0;
         HI_OUT        = '0;
         LO_OUT        = '0;
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// Directed and random vectors for mips_alu against an arithmetic reference model.
module tb_mips_alu;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] HI_IN = '0, LO_IN = '0, OperandA_IN = '0, OperandB_IN = '0;
   logic [5:0]  ALUControl_IN = '0;
   logic [4:0]  ShiftAmount_IN = '0;
   logic [31:0] ALUResult_OUT, HI_OUT, LO_OUT;

   int n_vec = 0;
   int n_bad = 0;

   always #5 CLOCK = ~CLOCK;

   mips_alu dut (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .HI_IN          (HI_IN),
      .LO_IN          (LO_IN),
      .OperandA_IN    (OperandA_IN),
      .OperandB_IN    (OperandB_IN),
      .ALUControl_IN  (ALUControl_IN),
      .ShiftAmount_IN (ShiftAmount_IN),
      .ALUResult_OUT  (ALUResult_OUT),
      .HI_OUT         (HI_OUT),
      .LO_OUT         (LO_OUT)
   );

   function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                                 input logic rst, output logic [31:0] r, output logic [31:0] h,
                                 output logic [31:0] l);
      longint          sa, sb, p, q, rm;
      longint unsigned ua, ub, up;
      int              vs;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      vs = int'(a[4:0]);
      r = 32'd0;
      h = hi;
      l = lo;
      case (int'(op))
         0, 1: r = a + b;
         2, 3: r = a - b;
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = ~(a | b);
         8:  r = (sa < sb) ? 32'd1 : 32'd0;
         9:  r = (ua < ub) ? 32'd1 : 32'd0;
         10: begin p = longint'(ub * (64'd1 << sh)); r = p[31:0]; end
         11: begin up = ub / (64'd1 << sh); r = up[31:0]; end
         12: begin p = sb >> sh; r = p[31:0]; end
         13: begin p = longint'(ub * (64'd1 << vs)); r = p[31:0]; end
         14: begin up = ub / (64'd1 << vs); r = up[31:0]; end
         15: begin p = sb >> vs; r = p[31:0]; end
         16: begin p = longint'(ub * 65536); r = p[31:0]; end
         17: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         18: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
         19: if (b != 0) begin
            q = sa / sb; rm = sa % sb;
            l = q[31:0]; h = rm[31:0];
         end
         20: if (b != 0) begin
            up = ua / ub; l = up[31:0];
            up = ua % ub; h = up[31:0];
         end
         21: r = hi;
         22: r = lo;
         23: h = a;
         24: l = a;
         25: r = a;
         26: r = b;
         default: r = 32'd0;
      endcase
      if (!rst) begin
         r = 32'd0; h = 32'd0; l = 32'd0;
      end
   endfunction

   task automatic expect_out(input string tag, input logic [31:0] er, input logic [31:0] eh,
                             input logic [31:0] el);
      n_vec++;
      assert (ALUResult_OUT === er) else begin
         n_bad++;
         $error("FAIL %s result: got %h want %h", tag, ALUResult_OUT, er);
      end
      assert (HI_OUT === eh) else begin
         n_bad++;
         $error("FAIL %s hi: got %h want %h", tag, HI_OUT, eh);
      end
      assert (LO_OUT === el) else begin
         n_bad++;
         $error("FAIL %s lo: got %h want %h", tag, LO_OUT, el);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] er, eh, el;
      model(ALUControl_IN, OperandA_IN, OperandB_IN, ShiftAmount_IN, HI_IN, LO_IN, RESET, er, eh, el);
      expect_out(tag, er, eh, el);
   endtask

   task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      @(negedge CLOCK);
      ALUControl_IN  = op;
      OperandA_IN    = a;
      OperandB_IN    = b;
      ShiftAmount_IN = sh;
      #1;
   endtask

   initial begin
      HI_IN = 32'h1111_2222;
      LO_IN = 32'h3333_4444;
      apply(6'd0, 32'h1234_5678, 32'h1, 5'd0);
      expect_out("reset", 32'h0, 32'h0, 32'h0);
      RESET = 1'b1;

      apply(6'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
      expect_out("add_ovf", 32'h8000_0000, 32'h1111_2222, 32'h3333_4444);
      apply(6'd2, 32'h0, 32'h1, 5'd0);
      expect_out("sub_wrap", 32'hFFFF_FFFF, 32'h1111_2222, 32'h3333_4444);
      apply(6'd8, 32'hFFFF_FFFF, 32'h1, 5'd0);
      expect_out("slt", 32'h1, HI_IN, LO_IN);
      apply(6'd9, 32'hFFFF_FFFF, 32'h1, 5'd0);
      expect_out("sltu", 32'h0, HI_IN, LO_IN);
      apply(6'd12, 32'h0, 32'h8000_0000, 5'd4);
      expect_out("sra4", 32'hF800_0000, HI_IN, LO_IN);
      apply(6'd14, 32'h24, 32'h8000_0000, 5'd0);
      expect_out("srlv", 32'h0800_0000, HI_IN, LO_IN);
      apply(6'd10, 32'h0, 32'hDEAD_BEEF, 5'd0);
      expect_out("sll0", 32'hDEAD_BEEF, HI_IN, LO_IN);
      apply(6'd15, 32'h1F, 32'h8000_0001, 5'd0);
      expect_out("srav31n", 32'hFFFF_FFFF, HI_IN, LO_IN);
      apply(6'd12, 32'h0, 32'h7FFF_FFFF, 5'd31);
      expect_out("sra31p", 32'h0, HI_IN, LO_IN);
      apply(6'd17, 32'hFFFF_FFFE, 32'h3, 5'd0);
      expect_out("mult", 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      apply(6'd18, 32'hFFFF_FFFE, 32'h3, 5'd0);
      expect_out("multu", 32'h0, 32'h2, 32'hFFFF_FFFA);
      apply(6'd19, 32'hFFFF_FFF9, 32'h2, 5'd0);
      expect_out("div_neg", 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      apply(6'd19, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      expect_out("div_min", 32'h0, 32'h0, 32'h8000_0000);
      apply(6'd20, 32'h1234_5678, 32'h0, 5'd0);
      expect_out("divu_z", 32'h0, 32'h1111_2222, 32'h3333_4444);
      apply(6'd19, 32'h1234_5678, 32'h0, 5'd0);
      expect_out("div_z", 32'h0, 32'h1111_2222, 32'h3333_4444);
      apply(6'd23, 32'h1234, 32'h0, 5'd0);
      expect_out("mthi", 32'h0, 32'h1234, 32'h3333_4444);
      HI_IN = 32'h1234;
      apply(6'd21, 32'h0, 32'h0, 5'd0);
      expect_out("mfhi", 32'h1234, 32'h1234, 32'h3333_4444);
      apply(6'd24, 32'h5678, 32'h0, 5'd0);
      expect_out("mtlo", 32'h0, 32'h1234, 32'h5678);
      apply(6'd16, 32'h0, 32'h0000_ABCD, 5'd0);
      expect_out("lui", 32'hABCD_0000, HI_IN, LO_IN);
      apply(6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      expect_out("rsvd63", 32'h0, HI_IN, LO_IN);

      apply(6'd17, 32'h0001_0000, 32'h0003_0000, 5'd0);
      RESET = 1'b0;
      #1;
      expect_out("rst_mult", 32'h0, 32'h0, 32'h0);
      RESET = 1'b1;
      #1;
      expect_out("rel_mult", 32'h0, 32'h3, 32'h0);

      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         logic [5:0]  op;
         op = (i % 5 == 0) ? 6'($urandom_range(27, 63)) : 6'($urandom_range(0, 26));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         HI_IN = $urandom;
         LO_IN = $urandom;
         RESET = ($urandom_range(0, 19) != 0);
         apply(op, a, b, 5'($urandom_range(0, 31)));
         check_model("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
